link_controller: RTL

Single-clock controller sequencing the deserializer-to-queue link. Replaces derived clocks with one-cycle clock enables (100 kHz, 10 kHz) generated from clock_1MHz. Runs a four-phase ack handshake with the deserializer, confirmed by the queue length. Arbitrates between deserializer enqueues and external dequeue requests on the shared queue, one queue operation per 10 kHz tick window.

---
 rtl/link_ctrl_pkg.sv | 9 +
 rtl/tick_gen.sv | 15 +
 rtl/link_controller.sv | 102 ++++++++++
 3 files changed

// File: rtl/link_ctrl_pkg.sv
// link_ctrl_pkg: shared states, grant encoding and default sizing for the link controller
package link_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ENQ, DEQ, CHECK, ACK} state_t;
  typedef enum logic {GRANT_ENQ, GRANT_DEQ} grant_t;
  localparam int DEF_DIV_FAST = 10;
  localparam int DEF_DIV_SLOW = 100;
  localparam int DEF_QUEUE_DEPTH = 8;
  localparam int DEF_ACK_TIMEOUT = 2000;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider emitting a one-cycle enable every DIV clocks
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/link_controller.sv
// link_controller: enqueue/dequeue arbitration and four-phase ack for the deserializer-to-queue link
module link_controller
  import link_ctrl_pkg::*;
#(
  parameter int DIV_FAST    = DEF_DIV_FAST,
  parameter int DIV_SLOW    = DEF_DIV_SLOW,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int LEN_W       = 4,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic             clock_1MHz,
  input  logic             rst,
  output logic             tick_100KHz,
  output logic             tick_10KHz,
  input  logic             data_ready_in,
  output logic             ack_out,
  output logic             enqueue_out,
  input  logic             dequeue_req_in,
  output logic             dequeue_out,
  input  logic [LEN_W-1:0] len_in,
  output logic             full_out,
  output logic             empty_out,
  output logic             error_out
);
  localparam int AW = $clog2(ACK_TIMEOUT);
  state_t state;
  grant_t op, prio;
  logic pend, need_low, can_enq, can_deq;
  logic [LEN_W-1:0] len_snap;
  logic [LEN_W:0] snap_x, len_exp;
  logic [AW-1:0] ack_cnt;
  tick_gen #(.DIV(DIV_FAST)) u_fast (.clk(clock_1MHz), .rst(rst), .tick(tick_100KHz));
  tick_gen #(.DIV(DIV_SLOW)) u_slow (.clk(clock_1MHz), .rst(rst), .tick(tick_10KHz));
  assign full_out = len_in == LEN_W'(QUEUE_DEPTH);
  assign empty_out = len_in == '0;
  // need_low forbids a second enqueue after an ack timeout until the deserializer drops its request
  assign can_enq = data_ready_in & ~full_out & ~need_low;
  assign can_deq = pend & ~empty_out;
  assign snap_x = {1'b0, len_snap};
  assign len_exp = op == GRANT_ENQ ? snap_x + (LEN_W+1)'(1) : snap_x - (LEN_W+1)'(1);
  always_ff @(posedge clock_1MHz)
    if (!rst) begin
      state <= IDLE;
      op <= GRANT_ENQ;
      prio <= GRANT_ENQ;
      pend <= 1'b0;
      need_low <= 1'b0;
      len_snap <= '0;
      ack_cnt <= '0;
      ack_out <= 1'b0;
      enqueue_out <= 1'b0;
      dequeue_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      if (dequeue_req_in) pend <= 1'b1;
      if (!data_ready_in) need_low <= 1'b0;
      case (state)
        IDLE:
          if (can_enq && (!can_deq || prio == GRANT_ENQ)) begin
            state <= ENQ;
            op <= GRANT_ENQ;
            enqueue_out <= 1'b1;
            len_snap <= len_in;
            if (can_deq) prio <= GRANT_DEQ;
          end else if (can_deq) begin
            state <= DEQ;
            op <= GRANT_DEQ;
            dequeue_out <= 1'b1;
            len_snap <= len_in;
            if (can_enq) prio <= GRANT_ENQ;
          end
        ENQ, DEQ:
          if (tick_10KHz) begin
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            state <= CHECK;
          end
        CHECK: begin
          if ({1'b0, len_in} != len_exp) error_out <= 1'b1;
          if (op == GRANT_ENQ) begin
            state <= ACK;
            ack_out <= 1'b1;
            ack_cnt <= '0;
          end else begin
            state <= IDLE;
            pend <= 1'b0;
          end
        end
        ACK:
          if (!data_ready_in) begin
            ack_out <= 1'b0;
            state <= IDLE;
          end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
            error_out <= 1'b1;
            ack_out <= 1'b0;
            need_low <= 1'b1;
            state <= IDLE;
          end else ack_cnt <= ack_cnt + AW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule
